// File: rtl/mc_pkg.sv
// Shared opcode and FSM state definitions for the multicycle sequencer and datapath.
package mc_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Opcodes that need the EXEC stage; everything else is resolved in DECODE.
    function automatic logic needs_exec(input logic [5:0] op);
        return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/mc_sequencer.sv
// Multicycle control FSM: fetches into ir, sequences DECODE/EXEC/MEM/WB and
// produces the PC write and memory/register strobes.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int PC_W = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    input  logic            alu_zero,
    output logic            pc_we,
    output logic [PC_W-1:0] pc_next,
    output logic [31:0]     ir,
    output logic            reg_we,
    output logic            dmem_re,
    output logic            dmem_we,
    output logic [2:0]      state,
    output logic            halted
);

    logic [2:0]      r_state;
    logic [31:0]     r_ir;
    logic [2:0]      w_state_next;
    logic            w_ir_load;
    logic            w_pc_we;
    logic [PC_W-1:0] w_pc_next;
    logic            w_reg_we;
    logic            w_dmem_re;
    logic            w_dmem_we;
    logic [5:0]      w_opcode;
    logic [31:0]     w_imm_sext;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_branch_target;

    assign w_opcode        = r_ir[31:26];
    assign w_imm_sext      = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_pc_inc        = pc + PC_W'(1);
    assign w_branch_target = pc + w_imm_sext[PC_W-1:0];

    always_comb begin
        w_state_next = r_state;
        w_ir_load    = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_next    = pc;
        w_reg_we     = 1'b0;
        w_dmem_re    = 1'b0;
        w_dmem_we    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (imem_ready) begin
                    w_ir_load    = 1'b1;
                    w_pc_we      = 1'b1;
                    w_pc_next    = w_pc_inc;
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_opcode == OP_J) begin
                    w_pc_we      = 1'b1;
                    w_pc_next    = r_ir[PC_W-1:0];
                    w_state_next = ST_FETCH;
                end else if (w_opcode == OP_HALT) begin
                    w_state_next = ST_HALT;
                end else if (needs_exec(w_opcode)) begin
                    w_state_next = ST_EXEC;
                end else begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_EXEC: begin
                case (w_opcode)
                    OP_R, OP_ADDI: w_state_next = ST_WB;
                    OP_LW, OP_SW:  w_state_next = ST_MEM;
                    OP_BEQ: begin
                        w_pc_we      = alu_zero;
                        w_pc_next    = w_branch_target;
                        w_state_next = ST_FETCH;
                    end
                    default:       w_state_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                // The access strobe is held every cycle until memory acknowledges.
                w_dmem_re = (w_opcode == OP_LW);
                w_dmem_we = (w_opcode == OP_SW);
                if (dmem_ready) begin
                    w_state_next = (w_opcode == OP_LW) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                w_reg_we     = 1'b1;
                w_state_next = ST_FETCH;
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase

        // Reset wins over any ready input arriving in the same cycle.
        if (rst) begin
            w_state_next = ST_FETCH;
            w_ir_load    = 1'b0;
            w_pc_we      = 1'b0;
            w_reg_we     = 1'b0;
            w_dmem_re    = 1'b0;
            w_dmem_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_ir    <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_ir_load) begin
                r_ir <= imem_rdata;
            end
        end
    end

    assign pc_we   = w_pc_we;
    assign pc_next = w_pc_next;
    assign ir      = r_ir;
    assign reg_we  = w_reg_we;
    assign dmem_re = w_dmem_re;
    assign dmem_we = w_dmem_we;
    assign state   = r_state;
    assign halted  = (r_state == ST_HALT);

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed scoreboard bench for mc_sequencer: each step pushes the expected
// outputs for that cycle and pops them when the outputs are sampled.
module tb_mc_sequencer;

    localparam int PC_W = 11;

    localparam logic [31:0] I_ADDI = 32'h2001_0005;
    localparam logic [31:0] I_LW   = 32'h8C01_0004;
    localparam logic [31:0] I_SW   = 32'hAC01_0004;
    localparam logic [31:0] I_BEQ  = 32'h1000_FFFE;
    localparam logic [31:0] I_J    = 32'h0800_07FF;
    localparam logic [31:0] I_HALT = 32'hFC00_0000;
    localparam logic [31:0] I_UNDF = 32'h3C00_1234;

    localparam logic [2:0] F = 3'd0;
    localparam logic [2:0] D = 3'd1;
    localparam logic [2:0] E = 3'd2;
    localparam logic [2:0] M = 3'd3;
    localparam logic [2:0] W = 3'd4;
    localparam logic [2:0] H = 3'd5;

    logic            clk;
    logic            rst;
    logic [PC_W-1:0] pc;
    logic [31:0]     imem_rdata;
    logic            imem_ready;
    logic            dmem_ready;
    logic            alu_zero;
    logic            pc_we;
    logic [PC_W-1:0] pc_next;
    logic [31:0]     ir;
    logic            reg_we;
    logic            dmem_re;
    logic            dmem_we;
    logic [2:0]      state;
    logic            halted;

    typedef struct {
        string           tag;
        logic [2:0]      st;
        logic            pwe;
        logic [PC_W-1:0] pn;
        logic            rwe;
        logic            re;
        logic            we;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    mc_sequencer #(.PC_W(PC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .alu_zero   (alu_zero),
        .pc_we      (pc_we),
        .pc_next    (pc_next),
        .ir         (ir),
        .reg_we     (reg_we),
        .dmem_re    (dmem_re),
        .dmem_we    (dmem_we),
        .state      (state),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, record what the outputs must be, then sample.
    task automatic applyStimulus(input string tag, input logic rs, input logic [PC_W-1:0] pcv,
                                 input logic imr, input logic [31:0] rdata, input logic dr,
                                 input logic az, input logic [2:0] st, input logic pwe,
                                 input logic [PC_W-1:0] pn, input logic rwe,
                                 input logic re, input logic we);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst        = rs;
        pc         = pcv;
        imem_ready = imr;
        imem_rdata = rdata;
        dmem_ready = dr;
        alu_zero   = az;
        e.tag = tag; e.st = st; e.pwe = pwe; e.pn = pn; e.rwe = rwe; e.re = re; e.we = we;
        sb.push_back(e);
        #2;
        got = sb.pop_front();
        checkOutput({got.tag, ".state"}, 32'(state), 32'(got.st));
        checkOutput({got.tag, ".pc_we"}, 32'(pc_we), 32'(got.pwe));
        if (got.pwe) checkOutput({got.tag, ".pc_next"}, 32'(pc_next), 32'(got.pn));
        checkOutput({got.tag, ".reg_we"}, 32'(reg_we), 32'(got.rwe));
        checkOutput({got.tag, ".dmem_re"}, 32'(dmem_re), 32'(got.re));
        checkOutput({got.tag, ".dmem_we"}, 32'(dmem_we), 32'(got.we));
        checkOutput({got.tag, ".halted"}, 32'(halted), 32'(got.st == H));
    endtask

    initial begin
        rst = 1'b1; pc = '0; imem_rdata = '0; imem_ready = 1'b0;
        dmem_ready = 1'b0; alu_zero = 1'b0;
        repeat (2) @(posedge clk);

        //              tag           rs  pc      imr rdata   dr  az  st pwe pn      rwe re we
        applyStimulus("reset",      0, 11'd0,  0, 32'd0,  0, 0, F, 0, 11'd0,  0, 0, 0);
        checkOutput("reset.ir", ir, 32'd0);

        applyStimulus("addi.f",     0, 11'd0,  1, I_ADDI, 0, 0, F, 1, 11'd1,  0, 0, 0);
        applyStimulus("addi.d",     0, 11'd1,  0, 32'd0,  0, 0, D, 0, 11'd0,  0, 0, 0);
        checkOutput("addi.ir", ir, I_ADDI);
        applyStimulus("addi.e",     0, 11'd1,  0, 32'd0,  0, 0, E, 0, 11'd0,  0, 0, 0);
        applyStimulus("addi.w",     0, 11'd1,  0, 32'd0,  0, 0, W, 0, 11'd0,  1, 0, 0);
        applyStimulus("addi.end",   0, 11'd1,  0, 32'd0,  0, 0, F, 0, 11'd0,  0, 0, 0);

        applyStimulus("lw.f",       0, 11'd1,  1, I_LW,   0, 0, F, 1, 11'd2,  0, 0, 0);
        applyStimulus("lw.d",       0, 11'd2,  0, 32'd0,  0, 0, D, 0, 11'd0,  0, 0, 0);
        applyStimulus("lw.e",       0, 11'd2,  0, 32'd0,  0, 0, E, 0, 11'd0,  0, 0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus("lw.wait",  0, 11'd2,  0, 32'd0,  0, 0, M, 0, 11'd0,  0, 1, 0);
        applyStimulus("lw.ack",     0, 11'd2,  0, 32'd0,  1, 0, M, 0, 11'd0,  0, 1, 0);
        applyStimulus("lw.w",       0, 11'd2,  0, 32'd0,  0, 0, W, 0, 11'd0,  1, 0, 0);

        applyStimulus("sw.f",       0, 11'd2,  1, I_SW,   0, 0, F, 1, 11'd3,  0, 0, 0);
        applyStimulus("sw.d",       0, 11'd3,  0, 32'd0,  0, 0, D, 0, 11'd0,  0, 0, 0);
        applyStimulus("sw.e",       0, 11'd3,  0, 32'd0,  0, 0, E, 0, 11'd0,  0, 0, 0);
        applyStimulus("sw.wait",    0, 11'd3,  0, 32'd0,  0, 0, M, 0, 11'd0,  0, 0, 1);
        applyStimulus("sw.ack",     0, 11'd3,  0, 32'd0,  1, 0, M, 0, 11'd0,  0, 0, 1);
        applyStimulus("sw.end",     0, 11'd3,  0, 32'd0,  0, 0, F, 0, 11'd0,  0, 0, 0);

        applyStimulus("beqt.f",     0, 11'd5,  1, I_BEQ,  0, 0, F, 1, 11'd6,  0, 0, 0);
        applyStimulus("beqt.d",     0, 11'd6,  0, 32'd0,  0, 1, D, 0, 11'd0,  0, 0, 0);
        applyStimulus("beqt.e",     0, 11'd6,  0, 32'd0,  0, 1, E, 1, 11'd4,  0, 0, 0);
        applyStimulus("beqn.f",     0, 11'd4,  1, I_BEQ,  0, 0, F, 1, 11'd5,  0, 0, 0);
        applyStimulus("beqn.d",     0, 11'd5,  0, 32'd0,  0, 0, D, 0, 11'd0,  0, 0, 0);
        applyStimulus("beqn.e",     0, 11'd5,  0, 32'd0,  0, 0, E, 0, 11'd0,  0, 0, 0);

        applyStimulus("j.f",        0, 11'h7FF, 1, I_J,   0, 0, F, 1, 11'h000, 0, 0, 0);
        applyStimulus("j.d",        0, 11'h000, 0, 32'd0, 0, 0, D, 1, 11'h7FF, 0, 0, 0);
        applyStimulus("j.end",      0, 11'h7FF, 0, 32'd0, 0, 0, F, 0, 11'd0,   0, 0, 0);

        applyStimulus("nop.f",      0, 11'h10, 1, I_UNDF, 0, 0, F, 1, 11'h11, 0, 0, 0);
        applyStimulus("nop.d",      0, 11'h11, 0, 32'd0,  0, 0, D, 0, 11'd0,  0, 0, 0);
        applyStimulus("nop.end",    0, 11'h11, 0, 32'd0,  0, 0, F, 0, 11'd0,  0, 0, 0);

        applyStimulus("rmem.f",     0, 11'h20, 1, I_LW,   0, 0, F, 1, 11'h21, 0, 0, 0);
        applyStimulus("rmem.d",     0, 11'h21, 0, 32'd0,  0, 0, D, 0, 11'd0,  0, 0, 0);
        applyStimulus("rmem.e",     0, 11'h21, 0, 32'd0,  0, 0, E, 0, 11'd0,  0, 0, 0);
        applyStimulus("rmem.wait",  0, 11'h21, 0, 32'd0,  0, 0, M, 0, 11'd0,  0, 1, 0);
        applyStimulus("rmem.rst",   1, 11'h21, 1, I_SW,   1, 1, M, 0, 11'd0,  0, 0, 0);
        applyStimulus("rmem.after", 0, 11'h21, 0, 32'd0,  0, 0, F, 0, 11'd0,  0, 0, 0);
        checkOutput("rmem.ir", ir, 32'd0);

        applyStimulus("rfetch.rst", 1, 11'h21, 1, I_ADDI, 0, 0, F, 0, 11'd0,  0, 0, 0);
        applyStimulus("rfetch.aft", 0, 11'h21, 0, 32'd0,  0, 0, F, 0, 11'd0,  0, 0, 0);
        checkOutput("rfetch.ir", ir, 32'd0);

        applyStimulus("halt.f",     0, 11'd0,  1, I_HALT, 0, 0, F, 1, 11'd1,  0, 0, 0);
        applyStimulus("halt.d",     0, 11'd1,  0, 32'd0,  0, 0, D, 0, 11'd0,  0, 0, 0);
        for (int i = 0; i < 10; i++)
            applyStimulus("halt.hold", 0, 11'd1, 1, I_ADDI, 1, 1, H, 0, 11'd0, 0, 0, 0);
        applyStimulus("halt.rst",   1, 11'd1,  1, I_ADDI, 1, 1, H, 0, 11'd0,  0, 0, 0);
        applyStimulus("halt.after", 0, 11'd1,  0, 32'd0,  0, 0, F, 0, 11'd0,  0, 0, 0);
        checkOutput("halt.ir", ir, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 The module SHALL have parameter PC_W, default 11, giving the word-address width of the program counter.
REQ-002 The module SHALL have input clk, 1 bit: clock; all state changes on its rising edge.
REQ-003 The module SHALL have input rst, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have input pc, PC_W bits: current value from the PC register.
REQ-005 The module SHALL have input imem_rdata, 32 bits: instruction word at pc.
REQ-006 The module SHALL have input imem_ready, 1 bit: imem_rdata valid this cycle.
REQ-007 The module SHALL have input dmem_ready, 1 bit: data-memory access completes this cycle.
REQ-008 The module SHALL have input alu_zero, 1 bit: ALU result equals zero.
REQ-009 The module SHALL have output pc_we, 1 bit: write-enable to the PC register.
REQ-010 The module SHALL have output pc_next, PC_W bits: value the PC register loads when pc_we=1.
REQ-011 The module SHALL have output ir, 32 bits: registered instruction.
REQ-012 The module SHALL have output reg_we, dmem_re and dmem_we, 1 bit each: register-file write, data-memory read and data-memory write strobes.
REQ-013 The module SHALL have output state, 3 bits: current FSM state code.
REQ-014 The module SHALL have output halted, 1 bit: high while in HALT.

Function
REQ-015 The FSM SHALL use the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and HALT=5.
REQ-016 In FETCH with imem_ready=1, ir SHALL load imem_rdata, pc_we=1, pc_next=pc+1 modulo 2^PC_W, and the next state SHALL be DECODE; with imem_ready=0 the FSM SHALL hold FETCH with pc_we=0.
REQ-017 Opcode SHALL be ir[31:26]: R=000000, ADDI=001000, LW=100011, SW=101011, BEQ=000100, J=000010, HALT=111111.
REQ-018 In DECODE, J SHALL assert pc_we with pc_next=ir[PC_W-1:0] and go to FETCH; HALT SHALL go to HALT; any undefined opcode SHALL be a NOP and go to FETCH; all others SHALL go to EXEC.
REQ-019 In EXEC, R and ADDI SHALL go to WB, and LW and SW SHALL go to MEM.
REQ-020 In EXEC, BEQ with alu_zero=1 SHALL assert pc_we with pc_next = pc + sign-extended ir[15:0], truncated to PC_W bits and wrapping, then go to FETCH; BEQ with alu_zero=0 SHALL go to FETCH with pc_we=0.
REQ-021 In MEM, dmem_re (LW) or dmem_we (SW) SHALL stay high every cycle until dmem_ready=1; then LW SHALL go to WB and SW to FETCH.
REQ-022 In WB, reg_we SHALL be high for exactly one cycle, then the state SHALL go to FETCH.
REQ-023 HALT SHALL be absorbing: all strobes 0, halted=1, and only rst exits it.
REQ-024 pc_we SHALL be high only in the cases listed in REQ-016, REQ-018 and REQ-020, and never more than once per instruction except a taken J or BEQ after the FETCH increment.
REQ-025 Strobes SHALL be decoded from state, opcode and ready inputs only; ir and state SHALL be registered.
REQ-026 PC arithmetic SHALL be modulo 2^PC_W; pc = 2^PC_W-1 SHALL fetch to pc_next=0.

Reset
REQ-027 When rst=1 at a rising clk edge, the next state SHALL be FETCH, ir SHALL be 0, halted SHALL be 0 and all strobes SHALL be 0, overriding any in-progress MEM wait or HALT.
REQ-028 rst SHALL take priority over imem_ready and dmem_ready in the same cycle.

Structure
REQ-029 The opcode constants and state encodings SHALL live in a shared package, mc_pkg, also used by the datapath.
REQ-030 The block SHALL be a single module; the next-PC adder/mux SHALL be inline, with no sub-module.

Verification
REQ-031 Reset, then an ADDI fetched with imem_ready=1 and pc=0 -> pc_we=1 with pc_next=1, then states DECODE, EXEC and WB, with reg_we for one cycle, then FETCH.
REQ-032 LW with dmem_ready low for 3 cycles -> dmem_re high for 4 cycles, then WB; SW instead -> FETCH with no reg_we.
REQ-033 BEQ at pc=5 with imm=0xFFFE and alu_zero=1 -> pc_next=4 (6-2); with alu_zero=0 -> no pc_we in EXEC.
REQ-034 J with ir[10:0]=0x7FF at pc=0x7FF -> FETCH pc_next=0 (wrap), then DECODE pc_next=0x7FF.
REQ-035 HALT opcode -> halted=1 and held for 10 cycles; rst mid-MEM and rst in HALT -> FETCH with all outputs 0.
